// File: rtl/gs_pkg.sv
// Shared definitions for the global-scheduler kernel loader: opcodes,
// one-hot control bit positions, FSM states and default widths.
package gs_pkg;

  localparam int K_WORD_WIDTH_DEF    = 32;
  localparam int K_OP_WIDTH_DEF      = 4;
  localparam int K_CONTROL_WIDTH_DEF = 9;
  localparam int K_ADDR_WIDTH_DEF    = 12;
  localparam int K_LEN_WIDTH_DEF     = 16;

  typedef enum logic [3:0] {
    OP_GRID  = 4'd0,
    OP_BLOCK = 4'd1,
    OP_PARAM = 4'd2,
    OP_INSTR = 4'd3,
    OP_CONST = 4'd4,
    OP_DATA  = 4'd5,
    OP_WARP  = 4'd6,
    OP_REG   = 4'd7,
    OP_START = 4'd15
  } opcode_t;

  localparam int BIT_GRID  = 0;
  localparam int BIT_BLOCK = 1;
  localparam int BIT_PARAM = 2;
  localparam int BIT_INSTR = 3;
  localparam int BIT_CONST = 4;
  localparam int BIT_DATA  = 5;
  localparam int BIT_WARP  = 6;
  localparam int BIT_REG   = 7;
  localparam int BIT_START = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_LAUNCH  = 2'd2
  } state_t;

endpackage

// File: rtl/gs_op_decode.sv
// Combinational kernel opcode decoder: opcode to one-hot section control.
// Undefined opcodes decode to an all-zero control word.
module gs_op_decode
  import gs_pkg::*;
#(
  parameter int K_OP_WIDTH      = K_OP_WIDTH_DEF,
  parameter int K_CONTROL_WIDTH = K_CONTROL_WIDTH_DEF
) (
  input  logic [K_OP_WIDTH-1:0]      opcode,
  output logic [K_CONTROL_WIDTH-1:0] control
);

  always_comb begin
    control = '0;
    case (opcode)
      K_OP_WIDTH'(OP_GRID):  control[BIT_GRID]  = 1'b1;
      K_OP_WIDTH'(OP_BLOCK): control[BIT_BLOCK] = 1'b1;
      K_OP_WIDTH'(OP_PARAM): control[BIT_PARAM] = 1'b1;
      K_OP_WIDTH'(OP_INSTR): control[BIT_INSTR] = 1'b1;
      K_OP_WIDTH'(OP_CONST): control[BIT_CONST] = 1'b1;
      K_OP_WIDTH'(OP_DATA):  control[BIT_DATA]  = 1'b1;
      K_OP_WIDTH'(OP_WARP):  control[BIT_WARP]  = 1'b1;
      K_OP_WIDTH'(OP_REG):   control[BIT_REG]   = 1'b1;
      K_OP_WIDTH'(OP_START): control[BIT_START] = 1'b1;
      default:               control = '0;
    endcase
  end

endmodule

// File: rtl/gs_kernel_loader.sv
// Kernel descriptor loader: latches scalar config, streams section payloads
// to a memory write port and raises a launch handshake on START.
module gs_kernel_loader
  import gs_pkg::*;
#(
  parameter int K_WORD_WIDTH    = K_WORD_WIDTH_DEF,
  parameter int K_OP_WIDTH      = K_OP_WIDTH_DEF,
  parameter int K_CONTROL_WIDTH = K_CONTROL_WIDTH_DEF,
  parameter int K_ADDR_WIDTH    = K_ADDR_WIDTH_DEF,
  parameter int K_LEN_WIDTH     = K_LEN_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  input  logic [K_WORD_WIDTH-1:0]          in_word,
  output logic                             in_ready,
  output logic                             wr_en,
  output logic [K_CONTROL_WIDTH-1:0]       wr_sel,
  output logic [K_ADDR_WIDTH-1:0]          wr_addr,
  output logic [K_WORD_WIDTH-1:0]          wr_data,
  output logic [K_WORD_WIDTH-K_OP_WIDTH-1:0] grid_size,
  output logic [K_WORD_WIDTH-K_OP_WIDTH-1:0] block_size,
  output logic [K_WORD_WIDTH-K_OP_WIDTH-1:0] warp_count,
  output logic [K_WORD_WIDTH-K_OP_WIDTH-1:0] reg_count,
  output logic                             launch_valid,
  input  logic                             launch_ready,
  output logic                             busy,
  output logic                             err_opcode,
  output logic                             err_nocfg,
  output logic                             err_wrap
);

  localparam int OPW = K_WORD_WIDTH - K_OP_WIDTH;

  state_t                     state, state_next;
  logic [K_CONTROL_WIDTH-1:0] ctrl;
  logic [K_CONTROL_WIDTH-1:0] section;
  logic [K_LEN_WIDTH-1:0]     remaining;
  logic [K_ADDR_WIDTH-1:0]    addr;
  logic                       grid_set, block_set;
  logic                       xfer, is_section, has_len, cfg_ok;
  logic [OPW-1:0]             operand;
  logic [K_LEN_WIDTH-1:0]     len;

  gs_op_decode #(
    .K_OP_WIDTH      (K_OP_WIDTH),
    .K_CONTROL_WIDTH (K_CONTROL_WIDTH)
  ) u_decode (
    .opcode  (in_word[K_WORD_WIDTH-1 -: K_OP_WIDTH]),
    .control (ctrl)
  );

  // in_ready is held low while reset is applied so nothing is taken during it
  assign in_ready   = rst_n && (state != ST_LAUNCH);
  assign busy       = (state != ST_IDLE);
  assign xfer       = in_valid && in_ready;
  assign operand    = in_word[OPW-1:0];
  assign len        = in_word[K_LEN_WIDTH-1:0];
  assign is_section = ctrl[BIT_PARAM] | ctrl[BIT_INSTR] | ctrl[BIT_CONST] | ctrl[BIT_DATA];
  assign has_len    = (len != '0);
  assign cfg_ok     = grid_set && block_set;

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (xfer && is_section && has_len)            state_next = ST_PAYLOAD;
        else if (xfer && ctrl[BIT_START] && cfg_ok)   state_next = ST_LAUNCH;
        else                                          state_next = ST_IDLE;
      end
      ST_PAYLOAD: begin
        if (xfer && remaining == K_LEN_WIDTH'(1))     state_next = ST_IDLE;
        else                                          state_next = ST_PAYLOAD;
      end
      ST_LAUNCH: begin
        if (launch_ready)                             state_next = ST_IDLE;
        else                                          state_next = ST_LAUNCH;
      end
      default:                                        state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en        <= 1'b0;
      wr_sel       <= '0;
      wr_addr      <= '0;
      wr_data      <= '0;
      grid_size    <= '0;
      block_size   <= '0;
      warp_count   <= '0;
      reg_count    <= '0;
      launch_valid <= 1'b0;
      err_opcode   <= 1'b0;
      err_nocfg    <= 1'b0;
      err_wrap     <= 1'b0;
      section      <= '0;
      remaining    <= '0;
      addr         <= '0;
      grid_set     <= 1'b0;
      block_set    <= 1'b0;
    end else begin
      wr_en        <= 1'b0;
      launch_valid <= (state_next == ST_LAUNCH);
      if (state == ST_IDLE && xfer) begin
        if (ctrl == '0)       err_opcode <= 1'b1;
        if (ctrl[BIT_GRID])   begin grid_size  <= operand; grid_set  <= 1'b1; end
        if (ctrl[BIT_BLOCK])  begin block_size <= operand; block_set <= 1'b1; end
        if (ctrl[BIT_WARP])   warp_count <= operand;
        if (ctrl[BIT_REG])    reg_count  <= operand;
        if (is_section && has_len) begin
          section   <= ctrl;
          remaining <= len;
          addr      <= '0;
        end
        if (ctrl[BIT_START] && !cfg_ok) err_nocfg <= 1'b1;
      end
      if (state == ST_PAYLOAD && xfer) begin
        wr_en     <= 1'b1;
        wr_sel    <= section;
        wr_addr   <= addr;
        wr_data   <= in_word;
        addr      <= addr + K_ADDR_WIDTH'(1);
        remaining <= remaining - K_LEN_WIDTH'(1);
        if (addr == '1) err_wrap <= 1'b1;
      end
      // Config flags are consumed by a completed launch; config values stay
      if (state == ST_LAUNCH && launch_ready) begin
        grid_set  <= 1'b0;
        block_set <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gs_kernel_loader.sv
// Directed self-checking bench for gs_kernel_loader; a second instance with a
// 2-bit address counter shares the input stream to exercise address wrap.
module tb_gs_kernel_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_word = 32'h0;
  logic        launch_ready = 1'b0;

  logic        in_ready, wr_en, launch_valid, busy, err_opcode, err_nocfg, err_wrap;
  logic [8:0]  wr_sel;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;
  logic [27:0] grid_size, block_size, warp_count, reg_count;

  logic        in_ready2, wr_en2, launch_valid2, busy2, err_opcode2, err_nocfg2, err_wrap2;
  logic [8:0]  wr_sel2;
  logic [1:0]  wr_addr2;
  logic [31:0] wr_data2;
  logic [27:0] grid_size2, block_size2, warp_count2, reg_count2;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  gs_kernel_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr), .wr_data(wr_data),
    .grid_size(grid_size), .block_size(block_size), .warp_count(warp_count), .reg_count(reg_count),
    .launch_valid(launch_valid), .launch_ready(launch_ready), .busy(busy),
    .err_opcode(err_opcode), .err_nocfg(err_nocfg), .err_wrap(err_wrap)
  );

  gs_kernel_loader #(.K_ADDR_WIDTH(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_word(in_word), .in_ready(in_ready2),
    .wr_en(wr_en2), .wr_sel(wr_sel2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .grid_size(grid_size2), .block_size(block_size2), .warp_count(warp_count2), .reg_count(reg_count2),
    .launch_valid(launch_valid2), .launch_ready(launch_ready), .busy(busy2),
    .err_opcode(err_opcode2), .err_nocfg(err_nocfg2), .err_wrap(err_wrap2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for exactly one clock; results are visible on return
  task automatic send(input logic [31:0] w);
    in_valid = 1'b1;
    in_word  = w;
    tick();
    in_valid = 1'b0;
    in_word  = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %0b want 0", in_ready); else pass_cnt++;
    total_cnt++; if (wr_en !== 1'b0) $display("FAIL rst_wr_en got %0b want 0", wr_en); else pass_cnt++;
    total_cnt++; if (launch_valid !== 1'b0) $display("FAIL rst_launch got %0b want 0", launch_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got %0b want 0", busy); else pass_cnt++;
    total_cnt++; if ({err_opcode, err_nocfg, err_wrap} !== 3'b000) $display("FAIL rst_errs got %b want 000", {err_opcode, err_nocfg, err_wrap}); else pass_cnt++;
    total_cnt++; if (grid_size !== 28'h0) $display("FAIL rst_grid got %h want 0", grid_size); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %0b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_config_launch();
    send({4'h0, 28'h10});
    send({4'h1, 28'h40});
    send({4'h6, 28'h2});
    send({4'h7, 28'h8});
    total_cnt++; if (grid_size !== 28'h10) $display("FAIL cfg_grid got %h want 10", grid_size); else pass_cnt++;
    total_cnt++; if (block_size !== 28'h40) $display("FAIL cfg_block got %h want 40", block_size); else pass_cnt++;
    total_cnt++; if (warp_count !== 28'h2) $display("FAIL cfg_warp got %h want 2", warp_count); else pass_cnt++;
    total_cnt++; if (reg_count !== 28'h8) $display("FAIL cfg_reg got %h want 8", reg_count); else pass_cnt++;
    send({4'hF, 28'h0});
    total_cnt++; if (launch_valid !== 1'b1) $display("FAIL launch_rise got %0b want 1", launch_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL launch_ready_low got %0b want 0", in_ready); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      total_cnt++; if (launch_valid !== 1'b1 || busy !== 1'b1) $display("FAIL launch_hold[%0d] got lv=%0b busy=%0b want 1 1", i, launch_valid, busy); else pass_cnt++;
    end
    launch_ready = 1'b1;
    tick();
    launch_ready = 1'b0;
    total_cnt++; if (launch_valid !== 1'b0) $display("FAIL launch_drop got %0b want 0", launch_valid); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL launch_idle got busy=%0b rdy=%0b want 0 1", busy, in_ready); else pass_cnt++;
    total_cnt++; if (grid_size !== 28'h10) $display("FAIL cfg_retain got %h want 10", grid_size); else pass_cnt++;
  endtask

  task automatic test_section_stream();
    send({4'h3, 28'd3});
    total_cnt++; if (busy !== 1'b1 || wr_en !== 1'b0) $display("FAIL instr_hdr got busy=%0b wr_en=%0b want 1 0", busy, wr_en); else pass_cnt++;
    send(32'hF000_00AA);
    total_cnt++; if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 9'h008, 12'd0, 32'hF000_00AA}) $display("FAIL instr_a got en=%0b sel=%h addr=%0d data=%h want 1 008 0 f00000aa", wr_en, wr_sel, wr_addr, wr_data); else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      tick();
      total_cnt++; if (wr_en !== 1'b0 || busy !== 1'b1) $display("FAIL instr_gap[%0d] got en=%0b busy=%0b want 0 1", i, wr_en, busy); else pass_cnt++;
    end
    send(32'h0000_00BB);
    total_cnt++; if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 9'h008, 12'd1, 32'h0000_00BB}) $display("FAIL instr_b got en=%0b sel=%h addr=%0d data=%h want 1 008 1 000000bb", wr_en, wr_sel, wr_addr, wr_data); else pass_cnt++;
    tick();
    total_cnt++; if (wr_en !== 1'b0) $display("FAIL instr_gap2 got %0b want 0", wr_en); else pass_cnt++;
    send(32'h9000_00CC);
    total_cnt++; if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 9'h008, 12'd2, 32'h9000_00CC}) $display("FAIL instr_c got en=%0b sel=%h addr=%0d data=%h want 1 008 2 900000cc", wr_en, wr_sel, wr_addr, wr_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL instr_done_busy got %0b want 0", busy); else pass_cnt++;
    tick();
    total_cnt++; if (wr_en !== 1'b0 || err_opcode !== 1'b0) $display("FAIL instr_after got en=%0b errop=%0b want 0 0", wr_en, err_opcode); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    send({4'h5, 28'd0});
    total_cnt++; if (wr_en !== 1'b0 || busy !== 1'b0) $display("FAIL data_zero got en=%0b busy=%0b want 0 0", wr_en, busy); else pass_cnt++;
    send({4'h4, 28'd1});
    total_cnt++; if (wr_en !== 1'b0 || busy !== 1'b1) $display("FAIL const_hdr got en=%0b busy=%0b want 0 1", wr_en, busy); else pass_cnt++;
    send(32'h9123_4567);
    total_cnt++; if ({wr_en, wr_sel, wr_addr, wr_data} !== {1'b1, 9'h010, 12'd0, 32'h9123_4567}) $display("FAIL const_d got en=%0b sel=%h addr=%0d data=%h want 1 010 0 91234567", wr_en, wr_sel, wr_addr, wr_data); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0 || err_opcode !== 1'b0) $display("FAIL const_done got busy=%0b errop=%0b want 0 0", busy, err_opcode); else pass_cnt++;
  endtask

  task automatic test_errors();
    send({4'h9, 28'h123});
    total_cnt++; if (err_opcode !== 1'b1) $display("FAIL err_opcode got %0b want 1", err_opcode); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL err_op_idle got rdy=%0b busy=%0b want 1 0", in_ready, busy); else pass_cnt++;
    // grid/block flags were consumed by the earlier launch
    send({4'hF, 28'h0});
    total_cnt++; if (err_nocfg !== 1'b1) $display("FAIL err_nocfg got %0b want 1", err_nocfg); else pass_cnt++;
    total_cnt++; if (launch_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL err_nolaunch got lv=%0b rdy=%0b want 0 1", launch_valid, in_ready); else pass_cnt++;
    tick();
    total_cnt++; if (launch_valid !== 1'b0 || err_opcode !== 1'b1) $display("FAIL err_sticky got lv=%0b errop=%0b want 0 1", launch_valid, err_opcode); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [1:0] exp_small [5];
    exp_small = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    send({4'h2, 28'd5});
    for (int i = 0; i < 5; i++) begin
      send(32'hA000_0000 + 32'(i));
      total_cnt++; if ({wr_en2, wr_sel2, wr_addr2, wr_data2} !== {1'b1, 9'h004, exp_small[i], 32'hA000_0000 + 32'(i)}) $display("FAIL wrap_small[%0d] got en=%0b sel=%h addr=%0d data=%h want 1 004 %0d %h", i, wr_en2, wr_sel2, wr_addr2, wr_data2, exp_small[i], 32'hA000_0000 + 32'(i)); else pass_cnt++;
      total_cnt++; if (wr_addr !== 12'(i)) $display("FAIL wrap_big_addr[%0d] got %0d want %0d", i, wr_addr, i); else pass_cnt++;
      if (i == 0) begin
        total_cnt++; if (err_wrap2 !== 1'b0) $display("FAIL wrap_early got %0b want 0", err_wrap2); else pass_cnt++;
      end
    end
    total_cnt++; if (err_wrap2 !== 1'b1) $display("FAIL wrap_flag got %0b want 1", err_wrap2); else pass_cnt++;
    total_cnt++; if (err_wrap !== 1'b0) $display("FAIL wrap_big_flag got %0b want 0", err_wrap); else pass_cnt++;
    total_cnt++; if (busy2 !== 1'b0) $display("FAIL wrap_done got %0b want 0", busy2); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    send({4'h5, 28'd4});
    send(32'h1111_1111);
    total_cnt++; if (wr_en !== 1'b1 || busy !== 1'b1) $display("FAIL mid_pre got en=%0b busy=%0b want 1 1", wr_en, busy); else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total_cnt++; if ({wr_en, wr_sel, wr_addr, wr_data, busy, err_wrap2} !== {1'b0, 9'h0, 12'h0, 32'h0, 1'b0, 1'b0}) $display("FAIL mid_payload_rst got en=%0b sel=%h addr=%0d data=%h busy=%0b ew=%0b want all 0", wr_en, wr_sel, wr_addr, wr_data, busy, err_wrap2); else pass_cnt++;
    rst_n = 1'b1;
    send({4'h0, 28'h3});
    send({4'h1, 28'h5});
    send({4'hF, 28'h0});
    total_cnt++; if (launch_valid !== 1'b1) $display("FAIL mid_launch_pre got %0b want 1", launch_valid); else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total_cnt++; if ({launch_valid, busy, grid_size, block_size} !== {1'b0, 1'b0, 28'h0, 28'h0}) $display("FAIL mid_launch_rst got lv=%0b busy=%0b grid=%h block=%h want 0 0 0 0", launch_valid, busy, grid_size, block_size); else pass_cnt++;
    rst_n = 1'b1;
    send({4'hF, 28'h0});
    total_cnt++; if (err_nocfg !== 1'b1 || launch_valid !== 1'b0) $display("FAIL post_rst_start got nocfg=%0b lv=%0b want 1 0", err_nocfg, launch_valid); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_config_launch();
    test_section_stream();
    test_back_to_back();
    test_errors();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gs_kernel_loader.md
Name: gs_kernel_loader

Overview:
Sequential successor to the global-scheduler kernel opcode decoder. It consumes the kernel descriptor word stream under a valid/ready handshake and decodes each header word's opcode into one-hot section controls. Scalar config values (grid, block, warp, reg) are latched. Multi-word sections (PARAM/INSTR/CONST/DATA) are streamed to a memory write port with an auto-incrementing address. On START, it raises a launch handshake to the warp dispatcher.

Parameters:
K_WORD_WIDTH, 32, width of descriptor word; opcode occupies the top K_OP_WIDTH bits
K_OP_WIDTH, 4, opcode bits
K_CONTROL_WIDTH, 9, one-hot control width (bit 8 = START)
K_ADDR_WIDTH, 12, section write address width
K_LEN_WIDTH, 16, payload length field, held in header bits [K_LEN_WIDTH-1:0]

Ports:
clk  in  1  single clock
rst_n  in  1  reset; synchronous, active-low
in_valid  in  1  descriptor word valid
in_word  in  K_WORD_WIDTH  descriptor word
in_ready  out  1  loader accepts word this cycle
wr_en  out  1  section write strobe
wr_sel  out  K_CONTROL_WIDTH  one-hot section of current write (bit 2 PARAM, 3 INSTR, 4 CONST, 5 DATA)
wr_addr  out  K_ADDR_WIDTH  word offset within section
wr_data  out  K_WORD_WIDTH  payload word
grid_size, block_size, warp_count, reg_count  out  K_WORD_WIDTH-K_OP_WIDTH each  latched operands
launch_valid  out  1  kernel ready to launch
launch_ready  in  1  dispatcher accepts launch
busy  out  1  state != IDLE
err_opcode  out  1  sticky: undefined opcode seen
err_nocfg  out  1  sticky: START before GRID and BLOCK set
err_wrap  out  1  sticky: payload address wrapped

Behaviour:
- Opcode map: 0 GRID (bit0), 1 BLOCK (bit1), 2 PARAM (bit2), 3 INSTR (bit3), 4 CONST (bit4), 5 DATA (bit5), 6 WARP (bit6), 7 REG (bit7), 15 START (bit8). All others are undefined: control is 0.
- A transfer occurs when in_valid && in_ready.
- FSM states: IDLE, PAYLOAD, LAUNCH.
- IDLE: in_ready=1.
  - GRID/BLOCK/WARP/REG header: operand (low K_WORD_WIDTH-K_OP_WIDTH bits) latched into its register. Visible the next cycle. grid_set/block_set flags are set by the corresponding header.
  - PARAM/INSTR/CONST/DATA header with length N>0: latch section select and remaining=N, clear address counter, go to PAYLOAD. N=0: header consumed, stay IDLE.
  - START with grid_set && block_set: go to LAUNCH. Otherwise set err_nocfg, stay IDLE.
  - Undefined opcode: word dropped, err_opcode set, stay IDLE.
- PAYLOAD: in_ready=1. Every accepted word is registered to the write port.
  - Word accepted at cycle t gives wr_en=1 at t+1, with wr_data=word, wr_sel=section, wr_addr=counter.
  - Counter increments modulo 2^K_ADDR_WIDTH. Wrap from all-ones to 0 sets err_wrap and writing continues.
  - Accepting the last word (remaining==1) returns to IDLE. The next header is accepted the following cycle.
  - Payload words are never decoded as opcodes.
- LAUNCH: in_ready=0, launch_valid=1 (registered, asserted the cycle after START accepted).
  - Held until launch_ready. Handshake cycle goes to IDLE, launch_valid=0 next cycle, grid_set/block_set cleared.
  - Config registers retain values.
  - launch_ready while not in LAUNCH is ignored.
- in_valid low mid-PAYLOAD: stall, no wr_en, state and counters held.
- Reset (rst_n=0 at clock edge, any state, including mid-PAYLOAD or LAUNCH) clears all outputs, registers, flags and counters to 0 and sets state IDLE. in_ready becomes 1 in the first cycle after reset deasserts.
- wr_en is 0 in every cycle without a registered payload write.
- Error flags clear only on reset.

Decomposition:
- Package gs_pkg: opcode enum (GRID..REG, START=15), one-hot control constants, FSM state typedef, default widths.
- Sub-module: the existing combinational opcode decoder, reused as gs_op_decode (opcode to one-hot control). The loader instantiates it, and the FSM plus datapath live in gs_kernel_loader.

Test Plan:
- Config and launch: GRID 0x10, BLOCK 0x40, WARP 2, REG 8, START. Expect grid_size=0x10, block_size=0x40, warp_count=2, reg_count=8; launch_valid one cycle after START; launch_ready asserted 3 cycles later gives IDLE and launch_valid=0.
- Section stream: INSTR header N=3, then words A,B,C with in_valid gapped. Expect 3 wr_en pulses, wr_sel=0x008, addr 0,1,2, data A,B,C; no writes in gap cycles; busy drops after C.
- Zero-length and back-to-back: DATA N=0 immediately followed by CONST N=1 word D. Expect no DATA write; one write with wr_sel=0x010, addr 0, data D.
- Errors: opcode 9, then START with no GRID. Expect err_opcode=1, err_nocfg=1, no launch_valid, in_ready stays 1.
- Wrap: K_ADDR_WIDTH=2, PARAM N=5. Expect addresses 0,1,2,3,0 and err_wrap=1 at the fifth write.
- Reset mid-operation: drop rst_n during PAYLOAD (after 1 of 4 words) and during LAUNCH. Expect all outputs 0 and IDLE next cycle; a subsequent START sets err_nocfg.
